// File: rtl/bft_pkg.sv
// Shared definitions for the BFT host injector: default packet layout,
// credit-return field width and FSM state encoding.
// Optional feature macro: RESEND_EN (adds the RESEND state).
package bft_pkg;

   // Default packet geometry
   localparam int unsigned PKT_PAYLOAD_BITS = 32;
   localparam int unsigned PKT_LEAF_BITS    = 5;
   localparam int unsigned PKT_PORT_BITS    = 4;
   localparam int unsigned PKT_ADDR_BITS    = 7;
   localparam int unsigned PKT_BITS         = 1 + PKT_LEAF_BITS + PKT_PORT_BITS
                                              + PKT_ADDR_BITS + PKT_PAYLOAD_BITS;

   // Default field offsets: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload
   localparam int unsigned PKT_PAYLOAD_LSB = 0;
   localparam int unsigned PKT_ADDR_LSB    = PKT_PAYLOAD_LSB + PKT_PAYLOAD_BITS;
   localparam int unsigned PKT_PORT_LSB    = PKT_ADDR_LSB + PKT_ADDR_BITS;
   localparam int unsigned PKT_LEAF_LSB    = PKT_PORT_LSB + PKT_PORT_BITS;
   localparam int unsigned PKT_VALID_BIT   = PKT_LEAF_LSB + PKT_LEAF_BITS;

   // A credit return carries its freed-slot count in the low payload bits
   localparam int unsigned RET_CNT_BITS = 8;

   typedef struct packed {
      logic                        valid;
      logic [PKT_LEAF_BITS-1:0]    leaf;
      logic [PKT_PORT_BITS-1:0]    port;
      logic [PKT_ADDR_BITS-1:0]    addr;
      logic [PKT_PAYLOAD_BITS-1:0] payload;
   } bft_pkt_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_BLOCK = 2'd1
`ifdef RESEND_EN
      , ST_RESEND = 2'd2
`endif
   } bft_state_e;

endpackage

// File: rtl/bft_host_injector_if.sv
// Host/BFT side bundle of the injector. master = host + BFT driver, slave = injector.
// Optional feature macro: RESEND_EN (adds the resend request).
interface bft_host_injector_if #(
   parameter int unsigned PACKET_BITS   = 49,
   parameter int unsigned PAYLOAD_BITS  = 32,
   parameter int unsigned NUM_LEAF_BITS = 5,
   parameter int unsigned NUM_PORT_BITS = 4,
   parameter int unsigned NUM_ADDR_BITS = 7
);
   logic [PAYLOAD_BITS-1:0]  din_stream;
   logic                     vld_stream;
   logic                     ack_stream;
   logic [NUM_LEAF_BITS-1:0] dest_leaf;
   logic [NUM_PORT_BITS-1:0] dest_port;
   logic [PACKET_BITS-1:0]   dout_host2bft;
   logic [PACKET_BITS-1:0]   din_bft2host;
   logic [NUM_ADDR_BITS:0]   credits;
   logic                     credit_err;
`ifdef RESEND_EN
   logic                     resend;

   modport master (output din_stream, vld_stream, dest_leaf, dest_port, din_bft2host, resend,
                   input  ack_stream, dout_host2bft, credits, credit_err);
   modport slave  (input  din_stream, vld_stream, dest_leaf, dest_port, din_bft2host, resend,
                   output ack_stream, dout_host2bft, credits, credit_err);
`else
   modport master (output din_stream, vld_stream, dest_leaf, dest_port, din_bft2host,
                   input  ack_stream, dout_host2bft, credits, credit_err);
   modport slave  (input  din_stream, vld_stream, dest_leaf, dest_port, din_bft2host,
                   output ack_stream, dout_host2bft, credits, credit_err);
`endif
endinterface

// File: rtl/bft_credit_counter.sv
// Free-slot credit pool: per-cycle send/return arithmetic, saturation at the
// pool size and a sticky overflow flag.
module bft_credit_counter
   import bft_pkg::*;
#(
   parameter int unsigned NUM_ADDR_BITS = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    send,
   input  logic [RET_CNT_BITS-1:0] ret_cnt,
   output logic [NUM_ADDR_BITS:0]  credits,
   output logic [NUM_ADDR_BITS:0]  credits_next_c,
   output logic                    credit_err
);
   localparam int unsigned CW   = NUM_ADDR_BITS + 1;
   localparam int unsigned SW   = ((CW > RET_CNT_BITS) ? CW : RET_CNT_BITS) + 1;
   localparam int unsigned POOL = 1 << NUM_ADDR_BITS;

   logic [CW-1:0] credits_q, credits_d;
   logic          err_q, err_d;
   logic [SW-1:0] sum_c;

   // Next credit value: send and return both apply, then clamp to the pool size
   always_comb begin
      err_d     = err_q;
      sum_c     = SW'(credits_q) + SW'(ret_cnt) - SW'(send);
      credits_d = CW'(sum_c);
      if (sum_c > SW'(POOL)) begin
         credits_d = CW'(POOL);
         err_d     = 1'b1;
      end
   end

   // Credit and error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         credits_q <= CW'(POOL);
         err_q     <= 1'b0;
      end else begin
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

   assign credits        = credits_q;
   assign credits_next_c = credits_d;
   assign credit_err     = err_q;

endmodule

// File: rtl/bft_host_injector.sv
// Host-to-BFT packet injector: wraps accepted host words into BFT packets,
// tracks leaf input-BRAM credits and stalls the host when the pool is empty.
// Optional feature macro: RESEND_EN (retransmit of the last packet on request).
module bft_host_injector
   import bft_pkg::*;
#(
   parameter int unsigned PACKET_BITS   = 49,
   parameter int unsigned PAYLOAD_BITS  = 32,
   parameter int unsigned NUM_LEAF_BITS = 5,
   parameter int unsigned NUM_PORT_BITS = 4,
   parameter int unsigned NUM_ADDR_BITS = 7
) (
   input  logic             clk,
   input  logic             reset,
   bft_host_injector_if.slave bus
);
   localparam int unsigned CW       = NUM_ADDR_BITS + 1;
   localparam int unsigned PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;

   bft_state_e               state_q, state_d;
   logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [PACKET_BITS-1:0]   dout_q, dout_d;
   logic [PACKET_BITS-1:0]   pkt_c;
   logic [RET_CNT_BITS-1:0]  ret_cnt_c;
   logic [CW-1:0]            credits_c, credits_next_c;
   logic                     ack_c, xfer_c;
`ifdef RESEND_EN
   logic [PACKET_BITS-1:0]   last_q, last_d;
`endif

   // Credit returns: valid packets addressed to the reserved port 0
   always_comb begin
      ret_cnt_c = '0;
      if (bus.din_bft2host[PACKET_BITS-1] &&
          (bus.din_bft2host[PORT_LSB +: NUM_PORT_BITS] == '0))
         ret_cnt_c = bus.din_bft2host[RET_CNT_BITS-1:0];
   end

   bft_credit_counter #(
      .NUM_ADDR_BITS (NUM_ADDR_BITS)
   ) u_credit (
      .clk            (clk),
      .reset          (reset),
      .send           (xfer_c),
      .ret_cnt        (ret_cnt_c),
      .credits        (credits_c),
      .credits_next_c (credits_next_c),
      .credit_err     (bus.credit_err)
   );

   // Accept only from RUN with credits left; resend request also stalls the host
`ifdef RESEND_EN
   assign ack_c = (credits_c != '0) && (state_q == ST_RUN) && !reset && !bus.resend;
`else
   assign ack_c = (credits_c != '0) && (state_q == ST_RUN) && !reset;
`endif
   assign xfer_c = bus.vld_stream && ack_c;
   assign pkt_c  = PACKET_BITS'({1'b1, bus.dest_leaf, bus.dest_port, addr_q, bus.din_stream});

   // Next state, output packet and address counter
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      dout_d  = '0;
`ifdef RESEND_EN
      last_d  = last_q;
`endif
      case (state_q)
         ST_RUN:   if (credits_next_c == '0) state_d = ST_BLOCK;
         ST_BLOCK: if (credits_next_c != '0) state_d = ST_RUN;
`ifdef RESEND_EN
         ST_RESEND: begin
            dout_d  = last_q;
            state_d = (credits_next_c != '0) ? ST_RUN : ST_BLOCK;
         end
`endif
         default:  state_d = ST_RUN;
      endcase
      if (xfer_c) begin
         dout_d = pkt_c;
         addr_d = addr_q + 1'b1;
`ifdef RESEND_EN
         last_d = pkt_c;
`endif
      end
`ifdef RESEND_EN
      if (bus.resend) begin
         state_d = ST_RESEND;
         dout_d  = '0;
      end
`endif
   end

   // State, address and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         addr_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
      end
   end

`ifdef RESEND_EN
   // Copy of the last emitted packet for retransmission
   always_ff @(posedge clk) begin
      if (reset) last_q <= '0;
      else       last_q <= last_d;
   end

   assign bus.dout_host2bft = bus.resend ? '0 : dout_q;
`else
   assign bus.dout_host2bft = dout_q;
`endif
   assign bus.ack_stream = ack_c;
   assign bus.credits    = credits_c;

endmodule

// File: tb/tb_bft_host_injector.sv
// Self-checking bench for bft_host_injector: table-driven vectors plus
// hand-written sequences, with a packet scoreboard queue.
module tb_bft_host_injector;
   import bft_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic rs;
   always #5 clk = ~clk;

   bft_host_injector_if #(.PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
                          .NUM_PORT_BITS(4), .NUM_ADDR_BITS(7)) bus ();

   bft_host_injector #(.PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
                       .NUM_PORT_BITS(4), .NUM_ADDR_BITS(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef RESEND_EN
   assign bus.resend = rs;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bft_pkt_t    exp_q[$];
   int unsigned m_credits;
   logic [6:0]  m_addr;
   logic        m_err;
   logic        m_rs_state;
   bft_pkt_t    m_last;

   typedef struct {
      logic        vld;
      logic [31:0] din;
      logic        rv;
      logic [3:0]  rport;
      logic [31:0] rpay;
      int unsigned exp_credits;
      logic        exp_err;
   } vec_t;
   vec_t tbl[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic bft_pkt_t mkret(input logic v, input logic [3:0] pt, input logic [31:0] pay);
      bft_pkt_t p;
      p = '{valid: v, leaf: 5'd0, port: pt, addr: 7'd0, payload: pay};
      return p;
   endfunction

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] lf,
                        input logic [3:0] pt, input bft_pkt_t rp);
      bus.vld_stream   = v;
      bus.din_stream   = d;
      bus.dest_leaf    = lf;
      bus.dest_port    = pt;
      bus.din_bft2host = rp;
   endtask

   // One clock: check ack before the edge, update the model, check outputs after it
   task automatic step();
      logic        m_ack, xfer, redrive;
      int unsigned ret;
      bft_pkt_t    rp, p;
      @(negedge clk);
      m_ack = (m_credits != 0) && !reset && !rs && !m_rs_state;
      check("ack", 64'(bus.ack_stream), 64'(m_ack));
      xfer    = bus.vld_stream && m_ack;
      redrive = m_rs_state && !rs;
      rp      = bus.din_bft2host;
      ret     = (rp.valid && rp.port == 4'd0) ? int'(rp.payload[7:0]) : 0;
      if (xfer) begin
         p = '{valid: 1'b1, leaf: bus.dest_leaf, port: bus.dest_port, addr: m_addr,
               payload: bus.din_stream};
         exp_q.push_back(p);
         m_last = p;
         m_addr = m_addr + 7'd1;
      end
      m_credits = m_credits - (xfer ? 1 : 0) + ret;
      if (m_credits > 128) begin
         m_credits = 128;
         m_err     = 1'b1;
      end
      m_rs_state = rs;
      @(posedge clk);
      #1;
      if (xfer)         check("pkt", 64'(bus.dout_host2bft), 64'(exp_q.pop_front()));
      else if (redrive) check("redrive_pkt", 64'(bus.dout_host2bft), 64'(m_last));
      else              check("idle_zero", 64'(bus.dout_host2bft), 64'd0);
      check("credits_model", 64'(bus.credits), 64'(m_credits));
      check("err_model", 64'(bus.credit_err), 64'(m_err));
   endtask

   // Reset with a word offered: nothing may be accepted or emitted
   task automatic do_reset();
      reset = 1'b1;
      rs    = 1'b0;
      drive(1'b1, 32'hDEAD_BEEF, 5'd1, 4'd1, mkret(1'b0, 4'd0, 32'd0));
      @(negedge clk);
      check("ack_in_reset", 64'(bus.ack_stream), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 4'd0, mkret(1'b0, 4'd0, 32'd0));
      m_credits  = 128;
      m_addr     = 7'd0;
      m_err      = 1'b0;
      m_rs_state = 1'b0;
      m_last     = '0;
      exp_q.delete();
      check("rst_credits", 64'(bus.credits), 64'd128);
      check("rst_err", 64'(bus.credit_err), 64'd0);
      check("rst_dout", 64'(bus.dout_host2bft), 64'd0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 32'hA0, 1'b0, 4'd0, 32'd0,        127, 1'b0};
      tbl[1]  = '{1'b1, 32'hA1, 1'b0, 4'd0, 32'd0,        126, 1'b0};
      tbl[2]  = '{1'b1, 32'hA2, 1'b0, 4'd0, 32'd0,        125, 1'b0};
      tbl[3]  = '{1'b1, 32'hA3, 1'b0, 4'd0, 32'd0,        124, 1'b0};
      tbl[4]  = '{1'b1, 32'hA4, 1'b0, 4'd0, 32'd0,        123, 1'b0};
      tbl[5]  = '{1'b0, 32'h0,  1'b0, 4'd0, 32'd0,        123, 1'b0};
      tbl[6]  = '{1'b1, 32'hB0, 1'b1, 4'd0, 32'd1,        123, 1'b0};
      tbl[7]  = '{1'b0, 32'h0,  1'b1, 4'd5, 32'd7,        123, 1'b0};
      tbl[8]  = '{1'b0, 32'h0,  1'b0, 4'd0, 32'd9,        123, 1'b0};
      tbl[9]  = '{1'b0, 32'h0,  1'b1, 4'd0, 32'h0000_0105, 128, 1'b0};
      tbl[10] = '{1'b0, 32'h0,  1'b1, 4'd0, 32'd5,        128, 1'b1};

      do_reset();

      // Table: sends to leaf 3 / port 2, mixed and ignored returns, saturation
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].vld, tbl[i].din, 5'd3, 4'd2, mkret(tbl[i].rv, tbl[i].rport, tbl[i].rpay));
         step();
         check($sformatf("credits_row%0d", i), 64'(bus.credits), 64'(tbl[i].exp_credits));
         check($sformatf("err_row%0d", i), 64'(bus.credit_err), 64'(tbl[i].exp_err));
      end
      drive(1'b0, 32'd0, 5'd0, 4'd0, mkret(1'b0, 4'd0, 32'd0));
      step();
      check("err_sticky", 64'(bus.credit_err), 64'd1);

      do_reset();

      // Drain the whole pool, then hold valid while blocked
      for (int i = 0; i < 128; i++) begin
         drive(1'b1, 32'h1000 + 32'(i), 5'd1, 4'd3, mkret(1'b0, 4'd0, 32'd0));
         step();
      end
      check("drained_credits", 64'(bus.credits), 64'd0);
      for (int i = 0; i < 3; i++) step();
      check("blocked_ack", 64'(bus.ack_stream), 64'd0);

      // Return 64 credits while blocked; next accepted word uses wrapped addr 0
      drive(1'b1, 32'h2000, 5'd1, 4'd3, mkret(1'b1, 4'd0, 32'h40));
      step();
      check("return_credits", 64'(bus.credits), 64'd64);
      drive(1'b1, 32'h2000, 5'd1, 4'd3, mkret(1'b0, 4'd0, 32'd0));
      step();
      check("wrap_addr", 64'(bus.dout_host2bft[38:32]), 64'd0);
      check("after_wrap_credits", 64'(bus.credits), 64'd63);

`ifdef RESEND_EN
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'hC0 + 32'(i), 5'd4, 4'd6, mkret(1'b0, 4'd0, 32'd0));
         step();
      end
      check("rs_last_addr", 64'(bus.dout_host2bft[38:32]), 64'd9);
      drive(1'b0, 32'd0, 5'd0, 4'd0, mkret(1'b0, 4'd0, 32'd0));
      rs = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rs_dout_zero", 64'(bus.dout_host2bft), 64'd0);
      end
      rs = 1'b0;
      step();
      check("rs_redrive_addr", 64'(bus.dout_host2bft[38:32]), 64'd9);
      check("rs_credits", 64'(bus.credits), 64'd118);
      step();
      check("rs_once", 64'(bus.dout_host2bft), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bft_host_injector.md
BFT_HOST_INJECTOR -- requirements
Module: bft_host_injector

Interface
REQ-001 Parameter PACKET_BITS, default 49: BFT packet width.
REQ-002 Parameter PAYLOAD_BITS, default 32: user payload width.
REQ-003 Parameter NUM_LEAF_BITS, default 5: destination leaf field width.
REQ-004 Parameter NUM_PORT_BITS, default 4: destination port field width.
REQ-005 Parameter NUM_ADDR_BITS, default 7: leaf input-BRAM address width; credit pool holds 2^NUM_ADDR_BITS entries.
REQ-006 Port clk, input, 1: single clock, 400 MHz interface domain.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port din_stream, input, PAYLOAD_BITS: host payload word.
REQ-009 Port vld_stream, input, 1: din_stream valid.
REQ-010 Port ack_stream, output, 1: injector accepts the word this cycle.
REQ-011 Port dest_leaf, input, NUM_LEAF_BITS: target leaf, sampled at acceptance.
REQ-012 Port dest_port, input, NUM_PORT_BITS: target input port, sampled at acceptance; value 0 reserved.
REQ-013 Port dout_host2bft, output, PACKET_BITS: packet toward the BFT.
REQ-014 Port din_bft2host, input, PACKET_BITS: packet from the BFT (credit returns).
REQ-015 Port credits, output, NUM_ADDR_BITS+1: current free-slot count.
REQ-016 Port credit_err, output, 1: sticky credit-overflow flag.
REQ-017 Port resend, input, 1: BFT retransmit request (present only with RESEND_EN).

Function
REQ-018 Packet layout SHALL be: [48] valid, [47:43] leaf, [42:39] port, [38:32] BRAM address, [31:0] payload.
REQ-019 ack_stream SHALL be combinational from registers only: high iff credits != 0, the FSM is in RUN, and reset is low.
REQ-020 A transfer SHALL occur when vld_stream and ack_stream are both high; the packet SHALL appear on dout_host2bft on the next cycle for exactly one cycle; otherwise dout_host2bft SHALL be all zeros.
REQ-021 Throughput SHALL be one packet per cycle while credits remain.
REQ-022 The address field SHALL come from a NUM_ADDR_BITS counter that increments per transfer and wraps from 127 to 0.
REQ-023 An incoming packet with valid=1 and port=0 SHALL be a credit return carrying its freed count in payload[7:0]; all other incoming packets SHALL be ignored.
REQ-024 Per cycle, credits_next = credits - transfer + returned; simultaneous send and return SHALL both apply.
REQ-025 If credits_next exceeds 2^NUM_ADDR_BITS, credits SHALL saturate at 128 and credit_err SHALL set and remain set until reset.
REQ-026 FSM states SHALL be RUN (credits > 0), BLOCK (credits == 0), and RESEND (RESEND_EN only).
REQ-027 FSM transitions SHALL be: RUN->BLOCK when credits_next == 0; BLOCK->RUN when credits_next > 0.

Reset
REQ-028 On reset, credits SHALL be 128, the address counter SHALL be 0, the FSM SHALL be in RUN, and dout_host2bft, ack_stream and credit_err SHALL be 0.
REQ-029 Reset mid-stream SHALL drop any pending packet without emitting it.

Configuration
REQ-030 With RESEND_EN defined, resend high SHALL force dout_host2bft to 0 and ack_stream to 0 and move any state to RESEND; credit returns SHALL still be processed.
REQ-031 With RESEND_EN defined, the cycle after resend falls, the last emitted packet SHALL be re-driven once with no credit consumed and no address advance, and the FSM SHALL then return to RUN or BLOCK according to credits.
REQ-032 Without RESEND_EN, the resend port and the RESEND state SHALL be absent.

Structure
REQ-033 Packet field offsets, layout constants and FSM state encoding SHALL live in shared package bft_pkg.
REQ-034 A single sub-module, bft_credit_counter, SHALL implement the credit arithmetic, saturation and credit_err.

Verification
REQ-035 Reset, then 5 words 0xA0..0xA4 to leaf 3, port 2 -> 5 consecutive packets with addr 0..4; credits = 123.
REQ-036 Stream 128 words -> ack_stream falls after the 128th; FSM in BLOCK; dout_host2bft stays 0 while vld_stream is held.
REQ-037 In BLOCK, inject a return with payload 0x40 -> credits = 64; ack_stream high next cycle; addr continues at 0 after wrap.
REQ-038 A send and a return of 1 in the same cycle -> credits unchanged.
REQ-039 At credits = 128, inject a return of 5 -> credits = 128; credit_err = 1 until reset.
REQ-040 RESEND_EN: emit packet addr 9, assert resend 3 cycles -> dout_host2bft = 0 throughout; the same addr-9 packet is re-driven once; credits unchanged.
